// File: rtl/ddmtd_lock_detector_if.sv
// Measurement/status bundle between the DDMTD phase path and the lock detector.
// With DDMTD_LOCK_STATS_EN defined it also carries stats_clr and peak_err.
interface ddmtd_lock_detector_if #(
  parameter int ERR_W = 16
);
  logic                    ena;
  logic                    phase_valid;
  logic signed [ERR_W-1:0] phase_err;
  logic        [1:0]       win_sel;
  logic                    locked;
  logic                    lock_lost;
  logic        [1:0]       state;
  logic        [ERR_W-1:0] abs_err;
  logic                    stall;
`ifdef DDMTD_LOCK_STATS_EN
  logic                    stats_clr;
  logic        [ERR_W-1:0] peak_err;

  modport master (
    output ena, phase_valid, phase_err, win_sel, stats_clr,
    input  locked, lock_lost, state, abs_err, stall, peak_err
  );
  modport slave (
    input  ena, phase_valid, phase_err, win_sel, stats_clr,
    output locked, lock_lost, state, abs_err, stall, peak_err
  );
`else
  modport master (
    output ena, phase_valid, phase_err, win_sel,
    input  locked, lock_lost, state, abs_err, stall
  );
  modport slave (
    input  ena, phase_valid, phase_err, win_sel,
    output locked, lock_lost, state, abs_err, stall
  );
`endif
endinterface

// File: rtl/ddmtd_lock_detector.sv
// Hysteretic lock/holdover FSM over windowed DDMTD phase measurements with a stall timer.
// Optional peak-error statistics are built when DDMTD_LOCK_STATS_EN is defined.
module ddmtd_lock_detector #(
  parameter int ERR_W     = 16,
  parameter int LOCK_N    = 16,
  parameter int UNLOCK_N  = 4,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  ddmtd_lock_detector_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ACQUIRE  = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_HOLDOVER = 2'b11
  } state_e;

  localparam logic [TIMEOUT_W-1:0] TIMER_MAX  = '1;
  localparam logic [TIMEOUT_W-1:0] TIMER_TERM = TIMER_MAX - 1'b1;
  localparam logic [CNT_W-1:0]     LOCK_CNT   = CNT_W'(LOCK_N);
  localparam logic [CNT_W-1:0]     UNLOCK_CNT = CNT_W'(UNLOCK_N);
  localparam logic [ERR_W-1:0]     ERR_MIN    = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [ERR_W-1:0]     ABS_MAX    = {1'b0, {(ERR_W-1){1'b1}}};

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] timer_q, timer_d;
  logic [ERR_W-1:0]     abs_q, abs_d;
  logic                 lost_q, lost_d;

  logic [ERR_W-1:0]     meas_abs;
  logic [ERR_W-1:0]     thr;
  logic [CNT_W-1:0]     cnt_inc;
  logic                 in_win;

  // Saturating magnitude: the most negative code would otherwise wrap to itself.
  always_comb begin
    if (bus.phase_err == ERR_MIN) begin
      meas_abs = ABS_MAX;
    end else if (bus.phase_err[ERR_W-1]) begin
      meas_abs = -bus.phase_err;
    end else begin
      meas_abs = bus.phase_err;
    end
    case (bus.win_sel)
      2'b00:   thr = ERR_W'(16);
      2'b01:   thr = ERR_W'(64);
      2'b10:   thr = ERR_W'(256);
      default: thr = ERR_W'(1024);
    endcase
  end

  assign in_win  = (meas_abs <= thr);
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    abs_d   = abs_q;
    lost_d  = 1'b0;
    if (bus.ena) begin
      if (bus.phase_valid) begin
        timer_d = '0;
        abs_d   = meas_abs;
        case (state_q)
          ST_UNLOCKED: begin
            if (in_win) begin
              state_d = ST_ACQUIRE;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_ACQUIRE: begin
            if (!in_win) begin
              state_d = ST_UNLOCKED;
              cnt_d   = '0;
            end else if (cnt_inc == LOCK_CNT) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
          ST_LOCKED: begin
            if (!in_win) begin
              state_d = ST_HOLDOVER;
              cnt_d   = CNT_W'(1);
            end
          end
          ST_HOLDOVER: begin
            if (in_win) begin
              state_d = ST_LOCKED;
              cnt_d   = '0;
            end else if (cnt_inc == UNLOCK_CNT) begin
              state_d = ST_UNLOCKED;
              cnt_d   = '0;
              lost_d  = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        endcase
      end else if (timer_q != TIMER_MAX) begin
        timer_d = timer_q + 1'b1;
        // Stream stalled: drop out of lock on the edge the timer saturates.
        if (timer_q == TIMER_TERM) begin
          state_d = ST_UNLOCKED;
          cnt_d   = '0;
          lost_d  = state_q[1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
      cnt_q   <= '0;
      timer_q <= '0;
      abs_q   <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      abs_q   <= abs_d;
      lost_q  <= lost_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.locked    = state_q[1];
  assign bus.lock_lost = lost_q;
  assign bus.abs_err   = abs_q;
  assign bus.stall     = (timer_q == TIMER_MAX);

`ifdef DDMTD_LOCK_STATS_EN
  logic [ERR_W-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (bus.ena) begin
      if (bus.stats_clr) begin
        peak_d = '0;
      end else if (bus.phase_valid) begin
        if (state_q == ST_ACQUIRE && state_d == ST_LOCKED) begin
          peak_d = '0;
        end else if (state_q[1] && meas_abs > peak_q) begin
          peak_d = meas_abs;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak_err = peak_q;
`endif

endmodule

// File: doc/ddmtd_lock_detector.md
Name: ddmtd_lock_detector

Overview:
Downstream consumer of the DDMTD beat-domain phase measurement (phase_valid strobe + signed phase_err), in parallel with the loop filter. Qualifies each measurement against a selectable window and runs a hysteretic lock FSM. Drives the lock/loss status pins. Detects a stalled measurement stream (no phase_valid) and forces unlock.

Parameters:
ERR_W, 16, phase error width (signed)
LOCK_N, 16, consecutive in-window measurements to declare lock (>=2)
UNLOCK_N, 4, consecutive out-of-window measurements in HOLDOVER to declare loss (>=2)
CNT_W, 8, hysteresis counter width (2^CNT_W > max(LOCK_N, UNLOCK_N))
TIMEOUT_W, 16, width of the stall timer in clk cycles

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; 0 freezes all state
phase_valid  input  1  one-cycle measurement strobe
phase_err  input  ERR_W  signed phase error, valid with phase_valid
win_sel  input  2  window: 00=+-16, 01=+-64, 10=+-256, 11=+-1024 (inclusive)
locked  output  1  1 in LOCKED or HOLDOVER
lock_lost  output  1  one-cycle pulse on transition to UNLOCKED from LOCKED/HOLDOVER
state  output  2  00 UNLOCKED, 01 ACQUIRE, 10 LOCKED, 11 HOLDOVER
abs_err  output  ERR_W  registered |phase_err| of last valid measurement
stall  output  1  1 while the stall timer is saturated

Behaviour:
- Reset: state=UNLOCKED, locked=0, lock_lost=0, abs_err=0, stall=0, hysteresis counter=0, stall timer=0.
- Reset is honoured mid-operation from any state; no pulse on lock_lost.
- Evaluation happens on an edge with ena=1 && phase_valid=1. All outputs update at that edge (1-cycle latency from the strobe).
- Absolute value is saturating: |-2^(ERR_W-1)| = 2^(ERR_W-1)-1. in_win = abs <= threshold(win_sel).
- win_sel is sampled at each evaluation. A change does not reset the counters.
- UNLOCKED: in -> ACQUIRE, cnt=1; out -> stay.
- ACQUIRE: in -> cnt+1; when cnt+1==LOCK_N -> LOCKED, cnt=0. out -> UNLOCKED, cnt=0, no lock_lost.
- LOCKED: in -> stay; out -> HOLDOVER, cnt=1.
- HOLDOVER: in -> LOCKED, cnt=0. out -> cnt+1; when cnt+1==UNLOCK_N -> UNLOCKED, cnt=0, lock_lost=1 for one cycle.
- Stall timer:
  - Increments each ena=1 cycle without phase_valid and saturates at 2^TIMEOUT_W-1.
  - Cleared to 0 by phase_valid.
  - stall = (timer == max).
  - On the edge where the timer reaches max: state forced to UNLOCKED and cnt=0. lock_lost pulses only if the prior state was LOCKED or HOLDOVER.
  - While stall=1 the state stays UNLOCKED.
  - If phase_valid and terminal count coincide, phase_valid wins: timer cleared, normal evaluation, no forced unlock.
- ena=0: state, counters, timer and abs_err hold. lock_lost=0. phase_valid is ignored.

Optional Feature:
DDMTD_LOCK_STATS_EN
- Defined:
  - Adds input stats_clr (1) and output peak_err (ERR_W).
  - peak_err <= max(peak_err, abs) on each evaluation while in LOCKED or HOLDOVER.
  - Cleared to 0 on reset, on stats_clr, and on the edge entering LOCKED from ACQUIRE.
  - stats_clr wins over a simultaneous update.
- Undefined: both ports absent. No peak register. All other behaviour is identical.

Test Plan:
- Bench config: LOCK_N=16, UNLOCK_N=4, TIMEOUT_W=8, win_sel=01.
- Acquire: 16 strobes with phase_err=+40 -> state 01 after the 1st, state 10 and locked=1 exactly at the 16th; after 15, locked=0.
- Acquire abort: 10 strobes of +40, then one of -65 -> state 00, lock_lost=0; the next in-window strobe gives state 01 with cnt restarting.
- Holdover recovery and loss:
  - From LOCKED, 3x +100 then +64 -> 11,11,11 then 10; locked stays 1.
  - Then 4x -100 -> state 00, one-cycle lock_lost=1, locked=0.
- Saturation/boundary: phase_err=16'h8000 -> abs_err=16'h7FFF, out-of-window; phase_err=-64 with win_sel=01 -> in-window.
- Stall:
  - From LOCKED, no strobes for 255 cycles -> stall=1, state 00, lock_lost pulse.
  - A strobe on the terminal cycle instead -> stall=0, state unchanged.
  - ena=0 for 500 cycles -> no stall, state held.
- Stats (macro on): in LOCKED apply errors 10, 50, 30 -> peak_err=50; stats_clr concurrent with err 60 -> peak_err=0.
